alu_ctrl_mdu: RTL

- Successor to the combinational ALU decoder. Keeps the same aluOp/funct decode, widened to a parametrised control width with extra R-type ops.
- Adds a sequential multiply/divide unit (MDU) with HI/LO registers and a stall handshake to the pipeline.
- Sits in the EX stage beside the ALU. Decode is combinational; mult/div run iteratively, one bit per cycle.

---
 rtl/alu_ctrl_mdu.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decode plus an iterative multiply/divide unit with HI/LO
// registers and a stall handshake back to the pipeline.
module alu_ctrl_mdu #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        aluOp,
    input  logic [5:0]        funct,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    output logic [CTRL_W-1:0] aluControl,
    output logic [DATA_W-1:0] mdu_rdata,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   acc_hi, acc_lo, mag_b;
    logic                op_mul, neg_q, neg_r;

    logic [3:0]          code;
    logic                mdu_sel, is_mdu, accept, is_signed;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   mag_a, mag_bv;
    logic [DATA_W:0]     mul_sum, div_part;
    logic                div_ge;
    logic [DATA_W-1:0]   div_diff, div_rem;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   q_fix, r_fix;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        code = 4'b0000;
        case (aluOp)
            2'b00:        code = 4'b0010;
            2'b01, 2'b11: code = 4'b0110;
            default: begin
                case (funct)
                    6'b100000: code = 4'b0010;
                    6'b100010: code = 4'b0110;
                    6'b100100: code = 4'b0000;
                    6'b100101: code = 4'b0001;
                    6'b101010: code = 4'b0111;
                    6'b101011: code = 4'b1000;
                    6'b100110: code = 4'b0011;
                    6'b100111: code = 4'b1100;
                    default:   code = 4'b0000;
                endcase
            end
        endcase
    end

    assign aluControl = CTRL_W'(code);

    assign mdu_sel = valid_in && (aluOp == 2'b10);
    assign is_mdu  = funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                   F_MULT, F_MULTU, F_DIV, F_DIVU};
    assign stall   = mdu_sel && is_mdu && (state != IDLE);
    assign accept  = mdu_sel && (state == IDLE);

    always_comb begin
        mdu_rdata = '0;
        if (mdu_sel && funct == F_MFHI)
            mdu_rdata = hi;
        else if (mdu_sel && funct == F_MFLO)
            mdu_rdata = lo;
    end

    // Iteration works on magnitudes; signs are restored in FIX.
    assign is_signed = (funct == F_MULT) || (funct == F_DIV);
    assign a_neg     = is_signed && srcA[DATA_W-1];
    assign b_neg     = is_signed && srcB[DATA_W-1];
    assign mag_a     = a_neg ? -srcA : srcA;
    assign mag_bv    = b_neg ? -srcB : srcB;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
    assign div_part = {acc_hi, acc_lo[DATA_W-1]};
    assign div_ge   = div_part >= {1'b0, mag_b};
    assign div_diff = div_part[DATA_W-1:0] - mag_b;
    assign div_rem  = div_ge ? div_diff : div_part[DATA_W-1:0];

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign q_fix    = neg_q ? -acc_lo : acc_lo;
    assign r_fix    = neg_r ? -acc_hi : acc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mag_b  <= '0;
            op_mul <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates on the same edge.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (funct)
                            F_MULT, F_MULTU: begin
                                state  <= MUL;
                                acc_hi <= '0;
                                acc_lo <= mag_a;
                                mag_b  <= mag_bv;
                                op_mul <= 1'b1;
                                neg_q  <= a_neg ^ b_neg;
                                neg_r  <= 1'b0;
                                count  <= '0;
                                busy   <= 1'b1;
                            end
                            F_DIV, F_DIVU: begin
                                op_mul <= 1'b0;
                                busy   <= 1'b1;
                                count  <= '0;
                                if (srcB == '0) begin
                                    // Divide by zero skips iteration; FIX writes these as-is.
                                    state  <= FIX;
                                    acc_hi <= srcA;
                                    acc_lo <= '1;
                                    neg_q  <= 1'b0;
                                    neg_r  <= 1'b0;
                                    done   <= 1'b1;
                                end else begin
                                    state  <= DIV;
                                    acc_hi <= '0;
                                    acc_lo <= mag_a;
                                    mag_b  <= mag_bv;
                                    neg_q  <= a_neg ^ b_neg;
                                    neg_r  <= a_neg;
                                end
                            end
                            F_MTHI:  hi <= srcA;
                            F_MTLO:  lo <= srcA;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[DATA_W:1];
                    acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FIX;
                        done  <= 1'b1;
                    end
                end
                DIV: begin
                    acc_hi <= div_rem;
                    acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FIX;
                        done  <= 1'b1;
                    end
                end
                FIX: begin
                    if (op_mul) begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
